// File: rtl/sm_rom_loader_pkg.sv
// Shared types and defaults for the UART-to-instruction-memory loader.
package sm_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    FULL  = 2'd3
  } loaderState_t;

  localparam int ADDR_W_DEF         = 11;
  localparam int TIMEOUT_CYCLES_DEF = 500000;
  localparam int BYTES_PER_WORD     = 4;

endpackage

// File: rtl/sm_rom_loader_if.sv
// UART byte stream in, instruction-memory write port out.
// rx_valid is a one-cycle strobe qualifying rx_byte with no backpressure; im_we
// qualifies im_wa/im_wd for exactly one cycle per word and the memory always accepts.
interface sm_rom_loader_if #(
  parameter int ADDR_W = 11
);
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] im_wa;
  logic [31:0]       im_wd;
  logic              im_we;

  modport master (
    input  rx_valid, rx_byte,
    output im_wa, im_wd, im_we
  );

  modport slave (
    output rx_valid, rx_byte,
    input  im_wa, im_wd, im_we
  );
endinterface

// File: rtl/sm_rom_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte strobe; a partial word is
// dropped after TIMEOUT_CYCLES idle cycles or when flush is raised.
module sm_byte_packer
  import sm_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       byteIdx;
  logic [1:0]       effIdx;
  logic [23:0]      shiftReg;
  logic [CNT_W-1:0] idleCnt;
  logic             expired;

  // On the expiry cycle the index already reads as 0, so a byte arriving then starts a new word.
  assign expired    = (byteIdx != 2'd0) && (idleCnt == CNT_W'(TIMEOUT_CYCLES));
  assign effIdx     = expired ? 2'd0 : byteIdx;
  assign word_valid = rx_valid && (effIdx == 2'(BYTES_PER_WORD - 1));
  assign word       = {rx_byte, shiftReg};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      byteIdx  <= 2'd0;
      shiftReg <= '0;
      idleCnt  <= '0;
    end else if (rx_valid) begin
      case (effIdx)
        2'd0:    shiftReg[7:0]   <= rx_byte;
        2'd1:    shiftReg[15:8]  <= rx_byte;
        2'd2:    shiftReg[23:16] <= rx_byte;
        default: ;
      endcase
      byteIdx <= effIdx + 2'd1;
      idleCnt <= '0;
    end else if (expired) begin
      byteIdx <= 2'd0;
      idleCnt <= '0;
    end else if (byteIdx != 2'd0) begin
      idleCnt <= idleCnt + 1'b1;
    end
  end
endmodule

// File: rtl/sm_rom_loader.sv
// Loader FSM: writes UART-assembled words into instruction memory or zeroes it.
// Optional running checksum of loaded words under ROM_LOADER_CHECKSUM_EN.
module sm_rom_loader
  import sm_loader_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear_req,
  sm_rom_loader_if.master      bus,
  output logic                 busy,
  output logic                 full,
  output logic [ADDR_W:0]      words_loaded,
  output logic [31:0]          checksum,
  output loaderState_t         dbgState
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  loaderState_t      state;
  logic [ADDR_W-1:0] loadAddr;
  logic              accept, goClear, startLoad, doWrite, wordValid;
  logic [31:0]       word;

  // Bytes arriving together with enable falling or clear_req are dropped.
  assign accept    = (state == LOAD) && enable && !clear_req;
  assign goClear   = clear_req && (state != CLEAR);
  assign startLoad = (state == IDLE) && enable && !clear_req;
  assign doWrite   = accept && wordValid;
  assign dbgState  = state;

  sm_byte_packer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .flush     (!accept),
    .rx_valid  (bus.rx_valid && accept),
    .rx_byte   (bus.rx_byte),
    .word_valid(wordValid),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.im_wa    <= '0;
      bus.im_wd    <= '0;
      bus.im_we    <= 1'b0;
      busy         <= 1'b0;
      full         <= 1'b0;
      words_loaded <= '0;
      loadAddr     <= '0;
    end else if (goClear) begin
      state     <= CLEAR;
      busy      <= 1'b1;
      bus.im_we <= 1'b1;
      bus.im_wa <= '0;
      bus.im_wd <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.im_we <= 1'b0;
          if (startLoad) begin
            state        <= LOAD;
            loadAddr     <= '0;
            words_loaded <= '0;
            full         <= 1'b0;
          end
        end
        LOAD: begin
          bus.im_we <= 1'b0;
          if (!enable) begin
            state <= IDLE;
          end else if (doWrite) begin
            bus.im_we <= 1'b1;
            bus.im_wa <= loadAddr;
            bus.im_wd <= word;
            if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + 1'b1;
            if (loadAddr == LAST_ADDR) begin
              full  <= 1'b1;
              state <= FULL;
            end else begin
              loadAddr <= loadAddr + 1'b1;
            end
          end
        end
        FULL: begin
          bus.im_we <= 1'b0;
          if (!enable) state <= IDLE;
        end
        CLEAR: begin
          if (bus.im_wa == LAST_ADDR) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bus.im_we <= 1'b0;
          end else begin
            bus.im_wa <= bus.im_wa + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0] sumReg;

  always_ff @(posedge clk) begin
    if (rst || startLoad) sumReg <= '0;
    else if (doWrite)     sumReg <= sumReg + word;
  end

  assign checksum = sumReg;
`else
  assign checksum = 32'd0;
`endif
endmodule

// File: tb/tb_sm_rom_loader.sv
// Self-checking bench for sm_rom_loader with a queue-based reference model
// and a write scoreboard; follows ROM_LOADER_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_sm_rom_loader;
  import sm_loader_pkg::*;

  localparam int AW    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst, enable, clear_req;
  logic              busy, full;
  logic [AW:0]       words_loaded;
  logic [31:0]       checksum;
  loaderState_t      dbgState;

  sm_rom_loader_if #(.ADDR_W(AW)) bus ();

  sm_rom_loader #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear_req   (clear_req),
    .bus         (bus.master),
    .busy        (busy),
    .full        (full),
    .words_loaded(words_loaded),
    .checksum    (checksum),
    .dbgState    (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (busy) busy_cnt++;
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(bus.im_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rom_write", 64'({bus.im_wa, bus.im_wd}), 64'(e));
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_part[$];
  int          m_last;
  int          m_addr, m_count;
  logic [31:0] m_sum;
  bit          m_full;

  function automatic void model_start();
    m_part.delete();
    m_addr  = 0;
    m_count = 0;
    m_sum   = 32'd0;
    m_full  = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c);
    logic [31:0] w;
    if (m_full) return;
    if (m_part.size() != 0 && (c - m_last) > TO) m_part.delete();
    m_part.push_back(b);
    m_last = c;
    if (m_part.size() == 4) begin
      w = {m_part[3], m_part[2], m_part[1], m_part[0]};
      exp_q.push_back({AW'(m_addr), w});
      m_sum = m_sum + w;
      m_count++;
      m_addr++;
      m_part.delete();
      if (m_addr == DEPTH) m_full = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_sum();
`ifdef ROM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 32'd0;
`endif
  endfunction

  function automatic void expect_clear();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), 32'd0});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    model_byte(b, cyc);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_load();
    enable = 1'b1;
    model_start();
    idle(1);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    busy_cnt  = 0;
    expect_clear();
    idle(1);
    clear_req = 1'b0;
  endtask

  task automatic check_drain(input string tag);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] tbl[8];
    tbl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
    rst = 1'b1; enable = 1'b0; clear_req = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    idle(3);
    check("rst_we", 64'(bus.im_we), 64'd0);
    check("rst_wa", 64'(bus.im_wa), 64'd0);
    check("rst_wd", 64'(bus.im_wd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_sum", 64'(checksum), 64'd0);
    check("rst_state", 64'(dbgState), 64'(IDLE));
    rst = 1'b0;
    idle(2);

    // two fixed words, back to back; first word's latency checked directly
    start_load();
    for (int i = 0; i < 8; i++) begin
      drive_byte(tbl[i]);
      if (i == 3) begin
        check("lat_we", 64'(bus.im_we), 64'd1);
        check("lat_word", 64'({bus.im_wa, bus.im_wd}), 64'({AW'(0), 32'h0000_0013}));
        check("lat_words", 64'(words_loaded), 64'd1);
      end
    end
    idle(3);
    check("t1_words", 64'(words_loaded), 64'(m_count));
    check("t1_sum", 64'(checksum), 64'(exp_sum()));
    check_drain("t1_drain");
    enable = 1'b0;
    idle(2);

    // partial word discarded by timeout
    start_load();
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom_range(0, 255)));
    idle(TO);
    for (int i = 1; i <= 4; i++) drive_byte(8'(i));
    idle(3);
    check("t2_words", 64'(words_loaded), 64'd1);
    check_drain("t2_drain");

    // randomized gaps clustered around the timeout boundary
    begin
      int gaps[6];
      gaps = '{0, 1, 2, TO - 1, TO, TO + 1};
      enable = 1'b0;
      idle(2);
      start_load();
      for (int i = 0; i < 36; i++) begin
        idle(gaps[$urandom_range(0, 5)]);
        drive_byte(8'($urandom_range(0, 255)));
      end
      idle(3);
      check("rnd_words", 64'(words_loaded), 64'(m_count));
      check("rnd_sum", 64'(checksum), 64'(exp_sum()));
      check_drain("rnd_drain");
    end

    // enable drop mid-word, byte coinciding with the drop is lost
    drive_byte(8'h11);
    drive_byte(8'h22);
    enable = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h33;
    idle(1);
    bus.rx_valid = 1'b0;
    check("drop_state", 64'(dbgState), 64'(IDLE));
    idle(2);
    start_load();
    drive_byte(8'hAA); drive_byte(8'hBB); drive_byte(8'hCC); drive_byte(8'hDD);
    idle(3);
    check("t4_words", 64'(words_loaded), 64'd1);
    check_drain("t4_drain");
    enable = 1'b0;
    idle(2);

    // clear from IDLE
    pulse_clear();
    idle(DEPTH + 4);
    check("clr_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
    check("clr_state", 64'(dbgState), 64'(IDLE));
    check_drain("clr_drain");

    // clear from LOAD with a byte in the same cycle
    start_load();
    drive_byte(8'h55);
    enable = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h66;
    pulse_clear();
    bus.rx_valid = 1'b0;
    idle(DEPTH + 4);
    check("clr2_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
    check("clr2_state", 64'(dbgState), 64'(IDLE));
    check_drain("clr2_drain");

    // fill memory: 17 words, last is ignored
    start_load();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) drive_byte(8'($urandom_range(0, 255)));
    idle(3);
    check("full_flag", 64'(full), 64'd1);
    check("full_state", 64'(dbgState), 64'(FULL));
    check("full_words", 64'(words_loaded), 64'(DEPTH));
    check("full_sum", 64'(checksum), 64'(exp_sum()));
    check_drain("full_drain");
    enable = 1'b0;
    idle(2);
    check("full_exit", 64'(dbgState), 64'(IDLE));
    check("full_sticky", 64'(full), 64'd1);

    // reset in the middle of a clear
    pulse_clear();
    idle(5);
    rst = 1'b1;
    idle(1);
    check("rstclr_we", 64'(bus.im_we), 64'd0);
    check("rstclr_busy", 64'(busy), 64'd0);
    check("rstclr_state", 64'(dbgState), 64'(IDLE));
    exp_q.delete();
    rst = 1'b0;
    idle(DEPTH + 4);
    check("rstclr_idle", 64'(dbgState), 64'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
